// File: rtl/load_bus_sequencer.sv
// load_bus_sequencer: arbitrates clock/alarm load requests and streams hr/min/sec over one shared bus.
module load_bus_sequencer #(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              time_req,
  input  logic [DATA_W-1:0] time_hr,
  input  logic [DATA_W-1:0] time_min,
  input  logic [DATA_W-1:0] time_sec,
  input  logic              alarm_req,
  input  logic [DATA_W-1:0] alarm_hr,
  input  logic [DATA_W-1:0] alarm_min,
  input  logic [DATA_W-1:0] alarm_sec,
  output logic [DATA_W-1:0] bus_data,
  output logic              ld_hr,
  output logic              ld_min,
  output logic              ld_sec,
  output logic              ld_alarm_hr,
  output logic              ld_alarm_min,
  output logic              ld_alarm_sec,
  output logic              time_ack,
  output logic              alarm_ack,
  output logic              time_nack,
  output logic              alarm_nack,
  output logic              on,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LD_HR, LD_MIN, LD_SEC, DONE, NACK} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic last_alarm_q, last_alarm_d;
  logic on_q, on_d;
  logic [DATA_W-1:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic alarm_elig, pick_alarm, valid;
  logic [DATA_W-1:0] in_hr, in_min, in_sec;
  // owner/last_alarm: 1 = alarm requester, 0 = time requester
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_alarm_d = last_alarm_q;
    hr_d         = hr_q;
    min_d        = min_q;
    sec_d        = sec_q;
    alarm_elig   = alarm_req & on_q;
    pick_alarm   = alarm_elig & (~time_req | ~last_alarm_q);
    in_hr        = pick_alarm ? alarm_hr  : time_hr;
    in_min       = pick_alarm ? alarm_min : time_min;
    in_sec       = pick_alarm ? alarm_sec : time_sec;
    valid        = (in_hr <= DATA_W'(23)) && (in_min <= DATA_W'(59)) && (in_sec <= DATA_W'(59));
    case (state_q)
      IDLE: if (time_req | alarm_elig) begin
        owner_d = pick_alarm;
        hr_d    = in_hr;
        min_d   = in_min;
        sec_d   = in_sec;
        state_d = valid ? LD_HR : NACK;
      end
      LD_HR:  state_d = LD_MIN;
      LD_MIN: state_d = LD_SEC;
      LD_SEC: state_d = DONE;
      DONE, NACK: begin
        state_d      = IDLE;
        last_alarm_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
    on_d = on_q | (state_d == DONE && !owner_d);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_alarm_q <= 1'b1;
      on_q         <= 1'b0;
      hr_q         <= '0;
      min_q        <= '0;
      sec_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_alarm_q <= last_alarm_d;
      on_q         <= on_d;
      hr_q         <= hr_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
    end
  end
  assign bus_data     = state_q == LD_HR ? hr_q : state_q == LD_MIN ? min_q : state_q == LD_SEC ? sec_q : '0;
  assign ld_hr        = state_q == LD_HR  && !owner_q;
  assign ld_min       = state_q == LD_MIN && !owner_q;
  assign ld_sec       = state_q == LD_SEC && !owner_q;
  assign ld_alarm_hr  = state_q == LD_HR  && owner_q;
  assign ld_alarm_min = state_q == LD_MIN && owner_q;
  assign ld_alarm_sec = state_q == LD_SEC && owner_q;
  assign time_ack     = state_q == DONE && !owner_q;
  assign alarm_ack    = state_q == DONE && owner_q;
  assign time_nack    = state_q == NACK && !owner_q;
  assign alarm_nack   = state_q == NACK && owner_q;
  assign on           = on_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_load_bus_sequencer.sv
// tb_load_bus_sequencer: scoreboard bench; expected bus events are queued as stimulus is driven.
module tb_load_bus_sequencer;
  localparam int W = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic time_req = 1'b0, alarm_req = 1'b0;
  logic [W-1:0] time_hr = '0, time_min = '0, time_sec = '0;
  logic [W-1:0] alarm_hr = '0, alarm_min = '0, alarm_sec = '0;
  logic [W-1:0] bus_data;
  logic ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec;
  logic time_ack, alarm_ack, time_nack, alarm_nack, on, busy;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  load_bus_sequencer #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .time_req(time_req), .time_hr(time_hr), .time_min(time_min), .time_sec(time_sec),
    .alarm_req(alarm_req), .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .bus_data(bus_data), .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
    .ld_alarm_hr(ld_alarm_hr), .ld_alarm_min(ld_alarm_min), .ld_alarm_sec(ld_alarm_sec),
    .time_ack(time_ack), .alarm_ack(alarm_ack), .time_nack(time_nack), .alarm_nack(alarm_nack),
    .on(on), .busy(busy)
  );

  always #5 clk = ~clk;

  // event code: 1-3 clock strobes, 4-6 alarm strobes, 7/8 acks, 9/10 nacks; low bits carry bus_data
  function automatic logic [9:0] observed();
    return ld_hr        ? {4'd1, bus_data} :
           ld_min       ? {4'd2, bus_data} :
           ld_sec       ? {4'd3, bus_data} :
           ld_alarm_hr  ? {4'd4, bus_data} :
           ld_alarm_min ? {4'd5, bus_data} :
           ld_alarm_sec ? {4'd6, bus_data} :
           time_ack     ? {4'd7, bus_data} :
           alarm_ack    ? {4'd8, bus_data} :
           time_nack    ? {4'd9, bus_data} :
           alarm_nack   ? {4'd10, bus_data} : 10'd0;
  endfunction

  task automatic tick();
    logic [9:0] ev, exp_ev;
    int n;
    @(posedge clk);
    #1;
    n = $countones({ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec});
    checks++;
    if (n > 1 || ((time_ack | alarm_ack) && (time_nack | alarm_nack)) ||
        (time_ack && alarm_ack) || (time_nack && alarm_nack)) begin
      errors++;
      $display("FAIL exclusive: strobes=%0d acks=%b%b nacks=%b%b required <=1 strobe, one response",
               n, time_ack, alarm_ack, time_nack, alarm_nack);
    end
    ev = observed();
    if (ev != 10'd0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got code=%0d data=%0d, required no event", ev[9:6], ev[5:0]);
      end else begin
        exp_ev = sb.pop_front();
        if (ev !== exp_ev) begin
          errors++;
          $display("FAIL event_order: got code=%0d data=%0d, required code=%0d data=%0d",
                   ev[9:6], ev[5:0], exp_ev[9:6], exp_ev[5:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_data, ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec,
         time_ack, alarm_ack, time_nack, alarm_nack, on, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: bus=%0d on=%b busy=%b, required all zero", bus_data, on, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || on !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b on=%b, required 0 0", busy, on);
    end
  endtask

  task automatic test_time_nack();
    time_hr = 6'd24; time_min = 6'd0; time_sec = 6'd0;
    sb.push_back({4'd9, 6'd0});
    time_req = 1'b1;
    tick();
    checks++;
    if (time_nack !== 1'b1 || busy !== 1'b1 || on !== 1'b0) begin
      errors++;
      $display("FAIL time_nack: nack=%b busy=%b on=%b, required 1 1 0", time_nack, busy, on);
    end
    time_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || on !== 1'b0 || time_nack !== 1'b0) begin
      errors++;
      $display("FAIL nack_return: busy=%b on=%b nack=%b, required 0 0 0", busy, on, time_nack);
    end
  endtask

  task automatic test_alarm_wait_then_time();
    bit bad = 1'b0;
    alarm_hr = 6'd6; alarm_min = 6'd15; alarm_sec = 6'd59;
    alarm_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || alarm_nack !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL alarm_wait: busy or nack seen while on=0, required idle");
    end
    time_hr = 6'd10; time_min = 6'd30; time_sec = 6'd45;
    sb.push_back({4'd1, 6'd10}); sb.push_back({4'd2, 6'd30});
    sb.push_back({4'd3, 6'd45}); sb.push_back({4'd7, 6'd0});
    sb.push_back({4'd4, 6'd6});  sb.push_back({4'd5, 6'd15});
    sb.push_back({4'd6, 6'd59}); sb.push_back({4'd8, 6'd0});
    time_req = 1'b1;
    tick();
    checks++;
    if (ld_hr !== 1'b1 || bus_data !== 6'd10 || on !== 1'b0) begin
      errors++;
      $display("FAIL time_ld_hr: ld_hr=%b bus=%0d on=%b, required 1 10 0", ld_hr, bus_data, on);
    end
    repeat (3) tick();
    checks++;
    if (time_ack !== 1'b1 || on !== 1'b1) begin
      errors++;
      $display("FAIL time_done: ack=%b on=%b, required 1 1", time_ack, on);
    end
    time_req = 1'b0;
    repeat (5) tick();
    checks++;
    if (alarm_ack !== 1'b1) begin
      errors++;
      $display("FAIL alarm_after_time: alarm_ack=%b, required 1", alarm_ack);
    end
    alarm_req = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0 || on !== 1'b1) begin
      errors++;
      $display("FAIL alarm_seq_end: pending=%0d on=%b, required 0 1", sb.size(), on);
    end
  endtask

  task automatic test_snapshot();
    time_hr = 6'd1; time_min = 6'd30; time_sec = 6'd5;
    sb.push_back({4'd1, 6'd1}); sb.push_back({4'd2, 6'd30});
    sb.push_back({4'd3, 6'd5}); sb.push_back({4'd7, 6'd0});
    time_req = 1'b1;
    tick();
    time_min = 6'd7;
    tick();
    checks++;
    if (ld_min !== 1'b1 || bus_data !== 6'd30) begin
      errors++;
      $display("FAIL snapshot: ld_min=%b bus=%0d, required 1 30", ld_min, bus_data);
    end
    repeat (2) tick();
    checks++;
    if (time_ack !== 1'b1 || on !== 1'b1) begin
      errors++;
      $display("FAIL snapshot_done: ack=%b on=%b, required 1 1", time_ack, on);
    end
    time_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    alarm_hr = 6'd23; alarm_min = 6'd59; alarm_sec = 6'd0;
    time_hr = 6'd0; time_min = 6'd0; time_sec = 6'd0;
    sb.push_back({4'd4, 6'd23}); sb.push_back({4'd5, 6'd59});
    sb.push_back({4'd6, 6'd0});  sb.push_back({4'd8, 6'd0});
    sb.push_back({4'd1, 6'd0});  sb.push_back({4'd2, 6'd0});
    sb.push_back({4'd3, 6'd0});  sb.push_back({4'd7, 6'd0});
    time_req = 1'b1;
    alarm_req = 1'b1;
    tick();
    checks++;
    if (ld_alarm_hr !== 1'b1 || ld_hr !== 1'b0 || bus_data !== 6'd23) begin
      errors++;
      $display("FAIL rr_first: ld_alarm_hr=%b ld_hr=%b bus=%0d, required 1 0 23", ld_alarm_hr, ld_hr, bus_data);
    end
    repeat (3) tick();
    checks++;
    if (alarm_ack !== 1'b1 || time_ack !== 1'b0) begin
      errors++;
      $display("FAIL rr_alarm_done: alarm_ack=%b time_ack=%b, required 1 0", alarm_ack, time_ack);
    end
    alarm_req = 1'b0;
    repeat (2) tick();
    checks++;
    if (ld_hr !== 1'b1 || ld_alarm_hr !== 1'b0) begin
      errors++;
      $display("FAIL rr_second: ld_hr=%b ld_alarm_hr=%b, required 1 0", ld_hr, ld_alarm_hr);
    end
    repeat (3) tick();
    checks++;
    if (time_ack !== 1'b1) begin
      errors++;
      $display("FAIL rr_time_done: time_ack=%b, required 1", time_ack);
    end
    time_req = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_end: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_alarm_nack();
    alarm_hr = 6'd1; alarm_min = 6'd1; alarm_sec = 6'd60;
    sb.push_back({4'd10, 6'd0});
    alarm_req = 1'b1;
    tick();
    checks++;
    if (alarm_nack !== 1'b1 || on !== 1'b1 || bus_data !== 6'd0) begin
      errors++;
      $display("FAIL alarm_nack: nack=%b on=%b bus=%0d, required 1 1 0", alarm_nack, on, bus_data);
    end
    alarm_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || alarm_nack !== 1'b0) begin
      errors++;
      $display("FAIL alarm_nack_end: busy=%b nack=%b, required 0 0", busy, alarm_nack);
    end
  endtask

  task automatic test_reset_mid();
    time_hr = 6'd1; time_min = 6'd2; time_sec = 6'd3;
    sb.push_back({4'd1, 6'd1}); sb.push_back({4'd2, 6'd2});
    time_req = 1'b1;
    repeat (2) tick();
    checks++;
    if (ld_min !== 1'b1 || bus_data !== 6'd2) begin
      errors++;
      $display("FAIL mid_ld_min: ld_min=%b bus=%0d, required 1 2", ld_min, bus_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_data, ld_hr, ld_min, ld_sec, ld_alarm_hr, ld_alarm_min, ld_alarm_sec,
         time_ack, alarm_ack, time_nack, alarm_nack, on, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset: bus=%0d ld_min=%b on=%b busy=%b, required all zero", bus_data, ld_min, on, busy);
    end
    time_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (on !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL mid_release: on=%b busy=%b pending=%0d, required 0 0 0", on, busy, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_time_nack();
    test_alarm_wait_then_time();
    test_snapshot();
    test_round_robin();
    test_alarm_nack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_bus_sequencer.md
LOAD_BUS_SEQUENCER -- requirements
Module: load_bus_sequencer

Interface
REQ-001 Parameter DATA_W, 6, width of every hr/min/sec field and of bus_data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 time_req  input  1  level request to load clock time; held until time_ack or time_nack.
REQ-005 time_hr, time_min, time_sec  input  DATA_W each  clock time to load.
REQ-006 alarm_req  input  1  level request to load alarm time; held until alarm_ack or alarm_nack.
REQ-007 alarm_hr, alarm_min, alarm_sec  input  DATA_W each  alarm time to load.
REQ-008 bus_data  output  DATA_W  shared single load bus to the clock/alarm registers.
REQ-009 ld_hr, ld_min, ld_sec  output  1 each  clock register load strobes.
REQ-010 ld_alarm_hr, ld_alarm_min, ld_alarm_sec  output  1 each  alarm register load strobes.
REQ-011 time_ack, alarm_ack  output  1 each  one-cycle pulse: requested load completed.
REQ-012 time_nack, alarm_nack  output  1 each  one-cycle pulse: request rejected, nothing loaded.
REQ-013 on  output  1  clock-run enable; sticky high after first successful time load.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, LD_HR, LD_MIN, LD_SEC, DONE, NACK; all outputs SHALL be registered/Moore-decoded from state and owner.
REQ-016 Requests SHALL be sampled only in IDLE; req changes in other states are ignored.
REQ-017 alarm_req SHALL NOT be granted while on=0; it waits without nack.
REQ-018 Both eligible in IDLE: round-robin, the requester not served last wins; after reset time wins first.
REQ-019 On grant the owner's hr/min/sec SHALL be snapshotted; later input changes do not affect the sequence.
REQ-020 Valid grant at cycle T: LD_HR at T+1, LD_MIN at T+2, LD_SEC at T+3, DONE at T+4, IDLE at T+5.
REQ-021 In LD_x, the owner's matching ld strobe SHALL be 1 and bus_data SHALL equal the snapshotted field; exactly one ld strobe high per cycle.
REQ-022 Outside LD_x states all ld strobes SHALL be 0 and bus_data SHALL be 0.
REQ-023 In DONE, owner's ack SHALL be 1 for exactly one cycle; for a time owner, on SHALL rise in the DONE cycle.
REQ-024 Validity: hr<=23, min<=59, sec<=59 (unsigned); any violation at grant SHALL go IDLE->NACK (T+1, owner nack=1)->IDLE (T+2), no strobes, on unchanged.
REQ-025 Requester SHALL drop req the cycle after ack/nack; req still high in IDLE starts a new transaction.
REQ-026 Once high, on SHALL stay high until reset; later time loads do not toggle it.
REQ-027 Round-robin pointer SHALL update on ack and on nack.
REQ-028 ack and nack SHALL never both be high; at most one requester's ack/nack high per cycle.

Reset
REQ-029 reset high SHALL immediately force state IDLE, on=0, busy=0, all ld strobes, acks, nacks=0, bus_data=0, pointer=time-first.
REQ-030 Reset mid-sequence SHALL abort with no further strobes; snapshot discarded; first rising edge after reset release evaluates IDLE.

Verification
REQ-031 time_req, 10/30/45 at T -> ld_hr bus=10 T+1, ld_min bus=30 T+2, ld_sec bus=45 T+3, time_ack and on=1 T+4.
REQ-032 alarm_req=1 with on=0 for 20 cycles -> no strobes, no nack; then time load -> alarm sequence starts in IDLE after time_ack.
REQ-033 on=1, time_req and alarm_req together twice -> first grant alarm (time served last), second time; alarm strobes use ld_alarm_*.
REQ-034 time_req with hr=24 -> time_nack at T+1, no ld strobes, on stays 0; sec=60 with alarm -> alarm_nack.
REQ-035 Change time_min from 30 to 7 at T+1 of a sequence -> bus_data=30 at T+2.
REQ-036 Assert reset during LD_MIN -> all outputs 0 same cycle, on=0; no ld_sec after release.
